// File: rtl/pulse_stretcher.sv
// Stretches 1-cycle event strobes into fixed-length LED blinks separated by a dark gap.
// Define PULSE_STRETCH_QUEUE_EN to queue events arriving mid-blink; otherwise they are dropped.
module pulse_stretcher #(
    parameter int unsigned ON_CYCLES  = 25_000_000,
    parameter int unsigned GAP_CYCLES = 12_500_000,
    parameter int unsigned PEND_W     = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pulse_in,
    input  logic              clear_ovf,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    output logic [1:0]        state_dbg
);

    localparam int unsigned MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int unsigned TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                level_q, level_d;
    logic                ovf_q, ovf_d;
    logic                timer_done;
    logic                evt_mid_blink;
    logic                lost;

    assign timer_done = (timer_q == '0);

    // Events that cannot start a blink right now: anywhere in ON, or in GAP before its last cycle.
    assign evt_mid_blink = pulse_in &&
                           ((state_q == S_ON) || ((state_q == S_GAP) && !timer_done));

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        lost    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pulse_in) begin
                    state_d = S_ON;
                    timer_d = ON_LOAD;
                end
            end
            S_ON: begin
                if (timer_done) begin
                    state_d = S_GAP;
                    timer_d = GAP_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_GAP: begin
                if (timer_done) begin
                    if (pulse_in || (pend_q != '0)) begin
                        state_d = S_ON;
                        timer_d = ON_LOAD;
                        // A fresh event in the final cycle replaces the queued one it would consume.
                        if (!pulse_in) begin
                            pend_d = pend_q - 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        if (evt_mid_blink) begin
`ifdef PULSE_STRETCH_QUEUE_EN
            if (pend_q == PEND_MAX) begin
                lost = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
`else
            lost = 1'b1;
`endif
        end

        // A loss in the same cycle as a clear keeps the flag set.
        ovf_d   = lost | (ovf_q & ~clear_ovf);
        level_d = (state_d == S_ON);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            level_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    assign level_out = level_q;
    assign busy      = (state_q != S_IDLE);
    assign pending   = pend_q;
    assign overflow  = ovf_q;
    assign state_dbg = state_q;

endmodule
